// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver.
//   Data width DATA_BITS (5..9), parity none/odd/even, 1 or 2 stop bits.
//   The line is sampled once per bit, using a 3-sample majority vote.
//   A start bit that has gone high again by its centre is rejected as a false start.
//   Parity, framing and break errors are reported with each character.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   i_rx         asynchronous serial line, idle high
//   o_data       received character, LSB first on the line; held until next o_vld
//   o_vld        one-cycle pulse when a character completes
//   o_parity_err parity mismatch (always 0 when PARITY = 0), held with o_data
//   o_frame_err  some stop bit sampled low, held with o_data
//   o_break      all-zero frame (data, parity and stop bits), held with o_data
//   o_state      debug view of the receiver state
//
// Output handshake: o_vld is a strobe with no back-pressure. o_data and the
// error flags are valid in the o_vld cycle and stay stable until the next o_vld.
module uart_rx_cfg #(
  parameter int FREQ      = 1_000_000,
  parameter int RATE      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_vld,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic [2:0]           o_state
);

  localparam int CPB  = FREQ / RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BCW  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t               state;
  logic                 sync1, sync2;
  logic [2:0]           hist;       // hist[0] is the newest synchronised sample
  logic [CW-1:0]        cnt;
  logic [BCW-1:0]       bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, par_err_q;
  logic                 stop_lo, stop_hi;   // any earlier stop bit seen low / high

  logic vote, fall, tick, half_tick, par_calc, frame_now, brk_now;

  always_comb begin
    vote      = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    fall      = hist[1] & ~hist[0];
    tick      = (cnt == CW'(CPB - 1));
    half_tick = (cnt == CW'(HALF - 1));
    // Even parity flags a 1 in the XOR of data and parity bit; odd parity flags a 0.
    par_calc  = ^{shreg, vote};
    if (PARITY == 1) par_calc = ~par_calc;
    // Evaluated on the last stop tick, with vote as the last stop bit.
    frame_now = stop_lo | ~vote;
    brk_now   = (shreg == '0) & ~par_bit & ~stop_hi & ~vote;
  end

  assign o_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      hist         <= 3'b111;
      state        <= S_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      par_err_q    <= 1'b0;
      stop_lo      <= 1'b0;
      stop_hi      <= 1'b0;
      o_data       <= '0;
      o_vld        <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      sync1 <= i_rx;
      sync2 <= sync1;
      hist  <= {hist[1:0], sync2};
      o_vld <= 1'b0;
      cnt   <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (fall) begin
            state     <= S_START;
            par_bit   <= 1'b0;
            par_err_q <= 1'b0;
            stop_lo   <= 1'b0;
            stop_hi   <= 1'b0;
          end
        end
        S_START: begin
          if (half_tick) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= vote ? S_IDLE : S_DATA;  // high at mid-start: false start
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt   <= '0;
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BCW'(DATA_BITS - 1)) begin
              bit_cnt  <= '0;
              stop_cnt <= 1'b0;
              state    <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            cnt       <= '0;
            par_bit   <= vote;
            par_err_q <= par_calc;
            stop_cnt  <= 1'b0;
            state     <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            cnt <= '0;
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              o_vld        <= 1'b1;
              o_data       <= shreg;
              o_parity_err <= par_err_q;
              o_frame_err  <= frame_now;
              o_break      <= brk_now;
              // After a framing error the line must idle a full bit before the
              // next start edge is trusted; a held-low line then reports once.
              state        <= frame_now ? S_WAIT_IDLE : S_IDLE;
            end else begin
              stop_cnt <= 1'b1;
              stop_lo  <= stop_lo | ~vote;
              stop_hi  <= stop_hi | vote;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (!vote) begin
            cnt <= '0;
          end else if (tick) begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg. Four receivers share one clock (8 clocks per bit):
//   u0: 8N1 on rx0
//   u1: 8E1 and u2: 8O1, both on rx1 (same frames, opposite parity sense)
//   u3: 7O2 on rx2
// Expected characters are queued per receiver and checked on each o_vld.
module tb_uart_rx_cfg;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic rx0, rx1, rx2;

  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic       v0, v1, v2, v3;
  logic       pe0, pe1, pe2, pe3;
  logic       fe0, fe1, fe2, fe3;
  logic       br0, br1, br2, br3;
  logic [2:0] st0, st1, st2, st3;

  logic [11:0] q0[$], q1[$], q2[$], q3[$];
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] pv = 4'b0;

  always #5 clk = ~clk;

  uart_rx_cfg u0 (.clk(clk), .rst_n(rst_n), .i_rx(rx0), .o_data(d0), .o_vld(v0),
    .o_parity_err(pe0), .o_frame_err(fe0), .o_break(br0), .o_state(st0));
  uart_rx_cfg #(.PARITY(2)) u1 (.clk(clk), .rst_n(rst_n), .i_rx(rx1), .o_data(d1),
    .o_vld(v1), .o_parity_err(pe1), .o_frame_err(fe1), .o_break(br1), .o_state(st1));
  uart_rx_cfg #(.PARITY(1)) u2 (.clk(clk), .rst_n(rst_n), .i_rx(rx1), .o_data(d2),
    .o_vld(v2), .o_parity_err(pe2), .o_frame_err(fe2), .o_break(br2), .o_state(st2));
  uart_rx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u3 (.clk(clk), .rst_n(rst_n),
    .i_rx(rx2), .o_data(d3), .o_vld(v3), .o_parity_err(pe3), .o_frame_err(fe3),
    .o_break(br3), .o_state(st3));

  // Result packing: {break, frame_err, parity_err, data[8:0]}
  task automatic check(input int inst, input logic [11:0] got, input logic prev);
    logic [11:0] want;
    bit have;
    have = 0;
    want = '0;
    case (inst)
      0: if (q0.size() != 0) begin want = q0.pop_front(); have = 1; end
      1: if (q1.size() != 0) begin want = q1.pop_front(); have = 1; end
      2: if (q2.size() != 0) begin want = q2.pop_front(); have = 1; end
      default: if (q3.size() != 0) begin want = q3.pop_front(); have = 1; end
    endcase
    vectors++;
    if (!have) begin
      miscompares++;
      $display("FAIL unexpected_vld u%0d got=%h want=none", inst, got);
    end else if (got !== want) begin
      miscompares++;
      $display("FAIL frame_u%0d got=%h want=%h", inst, got, want);
    end
    vectors++;
    if (prev) begin
      miscompares++;
      $display("FAIL vld_double u%0d got=two_cycles want=one_cycle", inst);
    end
  endtask

  always @(negedge clk) begin
    if (v0) check(0, {br0, fe0, pe0, 1'b0, d0}, pv[0]);
    if (v1) check(1, {br1, fe1, pe1, 1'b0, d1}, pv[1]);
    if (v2) check(2, {br2, fe2, pe2, 1'b0, d2}, pv[2]);
    if (v3) check(3, {br3, fe3, pe3, 2'b00, d3}, pv[3]);
    pv <= {v3, v2, v1, v0};
  end

  // Reference model: result of one frame from the character-level rules.
  function automatic logic [11:0] model(input logic [8:0] data, input int nbits,
                                        input int pmode, input logic pbit,
                                        input int nstop, input logic [1:0] stops);
    logic [8:0] d;
    int ones;
    logic perr, ferr, allz, brk;
    d = data & 9'((1 << nbits) - 1);
    ones = $countones(d) + ((pmode != 0) ? int'(pbit) : 0);
    perr = (pmode == 0) ? 1'b0 : (pmode == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    ferr = 1'b0;
    allz = 1'b1;
    for (int s = 0; s < nstop; s++) begin
      if (stops[s] == 1'b0) ferr = 1'b1;
      else allz = 1'b0;
    end
    brk = (d == 0) && (pmode == 0 || pbit == 1'b0) && allz;
    return {brk, ferr, perr, d};
  endfunction

  task automatic set_line(input int ln, input logic v);
    case (ln)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic send_bit(input int ln, input logic v, input bit glitch);
    for (int c = 0; c < CPB; c++) begin
      @(negedge clk);
      set_line(ln, (glitch && c == CPB / 2) ? ~v : v);
    end
  endtask

  task automatic idle_bits(input int ln, input int n);
    for (int c = 0; c < n * CPB; c++) begin
      @(negedge clk);
      set_line(ln, 1'b1);
    end
  endtask

  task automatic line_fmt(input int ln, output int nbits, output bit has_par,
                          output int nstop);
    nbits = (ln == 2) ? 7 : 8;
    has_par = (ln != 0);
    nstop = (ln == 2) ? 2 : 1;
  endtask

  task automatic send_frame(input int ln, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops, input int glitch_bit);
    int nbits, nstop;
    bit has_par;
    line_fmt(ln, nbits, has_par, nstop);
    send_bit(ln, 1'b0, 0);
    for (int i = 0; i < nbits; i++) send_bit(ln, data[i], glitch_bit == i);
    if (has_par) send_bit(ln, pbit, 0);
    for (int s = 0; s < nstop; s++) send_bit(ln, stops[s], 0);
  endtask

  task automatic check_zero(input string name, input logic [11:0] got);
    vectors++;
    if (got !== 12'h000) begin
      miscompares++;
      $display("FAIL %s got=%h want=000", name, got);
    end
  endtask

  typedef struct {
    int          ln;
    logic [8:0]  data;
    logic        pbit;
    logic [1:0]  stops;
    int          gap;
    logic [11:0] exp_a;   // u0, u1 (even) or u3
    logic [11:0] exp_b;   // u2 (odd) on line 1
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [8:0]  rd;
    logic        rp;
    logic [1:0]  rs;
    logic [11:0] ea, eb;
    int          ln, nbits, nstop, gap;
    bit          has_par;

    vecs[0] = '{0, 9'h06A, 1'b0, 2'b11, 0, 12'h06A, 12'h000};
    vecs[1] = '{0, 9'h000, 1'b0, 2'b11, 0, 12'h000, 12'h000};
    vecs[2] = '{0, 9'h0FF, 1'b0, 2'b11, 0, 12'h0FF, 12'h000};
    vecs[3] = '{0, 9'h055, 1'b0, 2'b10, 2, 12'h455, 12'h000};
    vecs[4] = '{0, 9'h033, 1'b0, 2'b11, 1, 12'h033, 12'h000};
    vecs[5] = '{1, 9'h0A5, 1'b0, 2'b11, 1, 12'h0A5, 12'h2A5};
    vecs[6] = '{1, 9'h0A5, 1'b1, 2'b11, 1, 12'h2A5, 12'h0A5};
    vecs[7] = '{2, 9'h041, 1'b1, 2'b11, 0, 12'h041, 12'h000};
    vecs[8] = '{2, 9'h07F, 1'b0, 2'b11, 1, 12'h07F, 12'h000};
    vecs[9] = '{2, 9'h041, 1'b1, 2'b01, 2, 12'h441, 12'h000};

    rst_n = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (5) @(negedge clk);
    check_zero("reset_u0", {v0, pe0, fe0, br0, d0});
    check_zero("reset_u1", {v1, pe1, fe1, br1, d1});
    check_zero("reset_u2", {v2, pe2, fe2, br2, d2});
    check_zero("reset_u3", {1'b0, v3, pe3, fe3, br3, d3});
    rst_n = 1'b1;
    idle_bits(0, 2);

    // Table-driven frames
    foreach (vecs[i]) begin
      case (vecs[i].ln)
        0: q0.push_back(vecs[i].exp_a);
        1: begin q1.push_back(vecs[i].exp_a); q2.push_back(vecs[i].exp_b); end
        default: q3.push_back(vecs[i].exp_a);
      endcase
      send_frame(vecs[i].ln, vecs[i].data, vecs[i].pbit, vecs[i].stops, -1);
      idle_bits(vecs[i].ln, vecs[i].gap);
    end
    idle_bits(0, 2);

    // Two-cycle glitch on an idle line: false start, nothing reported
    @(negedge clk); rx0 = 1'b0;
    @(negedge clk); rx0 = 1'b0;
    idle_bits(0, 3);
    q0.push_back(12'h05A);
    send_frame(0, 9'h05A, 1'b0, 2'b11, -1);
    idle_bits(0, 1);

    // One-cycle inversion at a data bit centre is out-voted
    q0.push_back(12'h06A);
    send_frame(0, 9'h06A, 1'b0, 2'b11, 3);
    q0.push_back(12'h06A);
    send_frame(0, 9'h06A, 1'b0, 2'b11, 1);
    idle_bits(0, 1);

    // Line held low for three frame times: a single break report
    q0.push_back(12'hC00);
    for (int c = 0; c < 30 * CPB; c++) begin
      @(negedge clk);
      rx0 = 1'b0;
    end
    idle_bits(0, 3);
    q0.push_back(12'h081);
    send_frame(0, 9'h081, 1'b0, 2'b11, -1);
    idle_bits(0, 1);

    // Reset mid-DATA abandons the frame
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    rx0 = 1'b1;
    @(negedge clk);
    check_zero("midframe_reset_u0", {v0, pe0, fe0, br0, d0});
    rst_n = 1'b1;
    idle_bits(0, 3);
    q0.push_back(12'h0C3);
    send_frame(0, 9'h0C3, 1'b0, 2'b11, -1);
    idle_bits(0, 2);

    // Randomised frames against the reference model
    for (int n = 0; n < 48; n++) begin
      ln = $urandom_range(0, 2);
      line_fmt(ln, nbits, has_par, nstop);
      rd = 9'($urandom);
      if ($urandom_range(0, 9) == 0) rd = '0;
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      case (ln)
        0: begin
          ea = model(rd, nbits, 0, 1'b0, nstop, rs);
          q0.push_back(ea);
        end
        1: begin
          ea = model(rd, nbits, 2, rp, nstop, rs);
          eb = model(rd, nbits, 1, rp, nstop, rs);
          q1.push_back(ea);
          q2.push_back(eb);
        end
        default: begin
          ea = model(rd, nbits, 1, rp, nstop, rs);
          q3.push_back(ea);
        end
      endcase
      gap = ea[10] ? 2 + $urandom_range(0, 1) : $urandom_range(0, 1);
      send_frame(ln, rd, rp, rs, -1);
      idle_bits(ln, gap);
    end
    idle_bits(0, 4);

    vectors++;
    if (q0.size() != 0) begin
      miscompares++;
      $display("FAIL missing_vld u0 got=%0d_pending want=0", q0.size());
    end
    vectors++;
    if (q1.size() != 0) begin
      miscompares++;
      $display("FAIL missing_vld u1 got=%0d_pending want=0", q1.size());
    end
    vectors++;
    if (q2.size() != 0) begin
      miscompares++;
      $display("FAIL missing_vld u2 got=%0d_pending want=0", q2.size());
    end
    vectors++;
    if (q3.size() != 0) begin
      miscompares++;
      $display("FAIL missing_vld u3 got=%0d_pending want=0", q3.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
